// File: rtl/mult_pkg.sv
// Shared types and constants for the HI/LO multiply controller.
// Imported by mult_hilo_ctrl and hilo_regs.
package mult_pkg;

   localparam int DATA_W         = 32;
   localparam int PROD_W         = 64;
   localparam int SETTLE_DEFAULT = 2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/hilo_regs.sv
// Architectural HI/LO register pair.
// Product capture wins over direct writes; writes while busy are dropped.
module hilo_regs
   import mult_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_busy,
   input  logic              i_capture,
   input  logic [PROD_W-1:0] i_product,
   input  logic              i_mthi_we,
   input  logic              i_mtlo_we,
   input  logic [DATA_W-1:0] i_mt_data,
   output logic [DATA_W-1:0] o_hi,
   output logic [DATA_W-1:0] o_lo,
   output logic              o_mt_drop
);

   logic [DATA_W-1:0] r_hi;
   logic [DATA_W-1:0] r_lo;
   logic              r_mt_drop;
   logic              w_mt_any;

   assign w_mt_any = i_mthi_we | i_mtlo_we;

   // HI/LO update: capture first, then direct writes outside MUL
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (i_capture) begin
         r_hi <= i_product[PROD_W-1:DATA_W];
         r_lo <= i_product[DATA_W-1:0];
      end else if (!i_busy) begin
         if (i_mthi_we) r_hi <= i_mt_data;
         if (i_mtlo_we) r_lo <= i_mt_data;
      end
   end

   // One-cycle pulse when a direct write arrives during MUL
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_mt_drop <= 1'b0;
      else       r_mt_drop <= i_busy & w_mt_any;
   end

   assign o_hi      = r_hi;
   assign o_lo      = r_lo;
   assign o_mt_drop = r_mt_drop;

endmodule

// File: rtl/mult_hilo_ctrl.sv
// Sequencer around the combinational Booth multiplier.
// Holds operands for SETTLE_CYCLES, then captures the product into HI/LO.
module mult_hilo_ctrl
   import mult_pkg::*;
#(
   parameter int SETTLE_CYCLES = SETTLE_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              op_valid,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic              op_ready,
   output logic [DATA_W-1:0] mul_a,
   output logic [DATA_W-1:0] mul_b,
   input  logic [PROD_W-1:0] mul_product,
   input  logic              mthi_we,
   input  logic              mtlo_we,
   input  logic [DATA_W-1:0] mt_data,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo,
   output logic              busy,
   output logic              done,
   output logic              mt_drop
);

   localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

   if (SETTLE_CYCLES < 1) begin : g_bad_settle
      $error("SETTLE_CYCLES must be >= 1");
   end

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_mul_a;
   logic [DATA_W-1:0] r_mul_b;
   logic              r_ready;
   logic              r_busy;
   logic              r_done;
   logic              w_in_mul;
   logic              w_capture;

   assign w_in_mul  = (r_state == S_MUL);
   assign w_capture = w_in_mul && (r_cnt == LAST_CNT);

   // Controller FSM with settle counter and registered handshake outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_mul_a <= '0;
         r_mul_b <= '0;
         r_ready <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE, S_DONE: begin
               r_done <= 1'b0;
               if (op_valid) begin
                  r_mul_a <= op_a;
                  r_mul_b <= op_b;
                  r_cnt   <= '0;
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= S_MUL;
               end else begin
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            S_MUL: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == LAST_CNT) begin
                  r_done  <= 1'b1;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_DONE;
               end
            end
            default: begin
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   hilo_regs u_hilo (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_busy    (w_in_mul),
      .i_capture (w_capture),
      .i_product (mul_product),
      .i_mthi_we (mthi_we),
      .i_mtlo_we (mtlo_we),
      .i_mt_data (mt_data),
      .o_hi      (hi),
      .o_lo      (lo),
      .o_mt_drop (mt_drop)
   );

   assign op_ready = r_ready;
   assign mul_a    = r_mul_a;
   assign mul_b    = r_mul_b;
   assign busy     = r_busy;
   assign done     = r_done;

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Directed bench for mult_hilo_ctrl with a behavioural signed multiplier.
// Checks are immediate assertions; summary printed at the end.
module tb_mult_hilo_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        op_valid;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        op_ready;
   logic [31:0] mul_a;
   logic [31:0] mul_b;
   logic [63:0] mul_product;
   logic        mthi_we;
   logic        mtlo_we;
   logic [31:0] mt_data;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;
   logic        mt_drop;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // stand-in for the combinational Booth multiplier
   assign mul_product = 64'($signed(longint'($signed(mul_a)) * longint'($signed(mul_b))));

   mult_hilo_ctrl #(.SETTLE_CYCLES(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .op_valid    (op_valid),
      .op_a        (op_a),
      .op_b        (op_b),
      .op_ready    (op_ready),
      .mul_a       (mul_a),
      .mul_b       (mul_b),
      .mul_product (mul_product),
      .mthi_we     (mthi_we),
      .mtlo_we     (mtlo_we),
      .mt_data     (mt_data),
      .hi          (hi),
      .lo          (lo),
      .busy        (busy),
      .done        (done),
      .mt_drop     (mt_drop)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo,
                         input string tag);
      op_valid = 1'b1;
      op_a = a;
      op_b = b;
      tick();
      op_valid = 1'b0;
      for (int i = 0; i < 10 && !done; i++) tick();
      chk({tag, "_done"}, 64'(done), 64'd1);
      chk({tag, "_hi"}, 64'(hi), 64'(ehi));
      chk({tag, "_lo"}, 64'(lo), 64'(elo));
      tick();
   endtask

   logic [31:0] pa, pb;
   logic        acc;
   logic [63:0] exp_p;
   int          ntx;

   initial begin
      rst = 1'b1;
      op_valid = 1'b0;
      op_a = '0;
      op_b = '0;
      mthi_we = 1'b0;
      mtlo_we = 1'b0;
      mt_data = '0;
      #12;
      chk("rst_hi", 64'(hi), 64'd0);
      chk("rst_lo", 64'(lo), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_mula", 64'(mul_a), 64'd0);
      chk("rst_drop", 64'(mt_drop), 64'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("rst_ready", 64'(op_ready), 64'd1);

      // 7 x -3, latency and busy window
      op_valid = 1'b1;
      op_a = 32'd7;
      op_b = 32'hFFFF_FFFD;
      tick();
      op_valid = 1'b0;
      chk("c1_busy", 64'(busy), 64'd1);
      chk("c1_ready", 64'(op_ready), 64'd0);
      chk("c1_mula", 64'(mul_a), 64'd7);
      chk("c1_mulb", 64'(mul_b), 64'hFFFF_FFFD);
      chk("c1_done", 64'(done), 64'd0);
      tick();
      chk("c2_busy", 64'(busy), 64'd1);
      chk("c2_done", 64'(done), 64'd0);
      tick();
      chk("c3_done", 64'(done), 64'd1);
      chk("c3_busy", 64'(busy), 64'd0);
      chk("c3_ready", 64'(op_ready), 64'd1);
      chk("c3_hi", 64'(hi), 64'hFFFF_FFFF);
      chk("c3_lo", 64'(lo), 64'hFFFF_FFEB);

      // back-to-back 5 x 6 from DONE
      op_valid = 1'b1;
      op_a = 32'd5;
      op_b = 32'd6;
      tick();
      op_valid = 1'b0;
      chk("b2b_busy", 64'(busy), 64'd1);
      chk("b2b_mula", 64'(mul_a), 64'd5);
      tick();
      chk("b2b_nodone", 64'(done), 64'd0);
      tick();
      chk("b2b_done", 64'(done), 64'd1);
      chk("b2b_hi", 64'(hi), 64'd0);
      chk("b2b_lo", 64'(lo), 64'd30);
      tick();
      chk("pulse_done", 64'(done), 64'd0);
      chk("idle_ready", 64'(op_ready), 64'd1);

      // corner operands
      do_mul(32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, "minmin");
      do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, "m1m1");

      // direct write in IDLE
      mthi_we = 1'b1;
      mt_data = 32'hDEAD_BEEF;
      tick();
      mthi_we = 1'b0;
      chk("mthi_hi", 64'(hi), 64'hDEAD_BEEF);
      chk("mthi_lo", 64'(lo), 64'd1);

      // direct write during MUL is dropped
      op_valid = 1'b1;
      op_a = 32'h10;
      op_b = 32'h10;
      tick();
      op_valid = 1'b0;
      mthi_we = 1'b1;
      mt_data = 32'h1234_5678;
      tick();
      mthi_we = 1'b0;
      chk("drop_pulse", 64'(mt_drop), 64'd1);
      chk("drop_hi", 64'(hi), 64'hDEAD_BEEF);
      tick();
      chk("drop_off", 64'(mt_drop), 64'd0);
      chk("drop_cap_done", 64'(done), 64'd1);
      chk("drop_cap_hi", 64'(hi), 64'd0);
      chk("drop_cap_lo", 64'(lo), 64'd256);

      // both direct writes in DONE override the capture
      mthi_we = 1'b1;
      mtlo_we = 1'b1;
      mt_data = 32'hA5A5_A5A5;
      tick();
      mthi_we = 1'b0;
      mtlo_we = 1'b0;
      chk("ovr_hi", 64'(hi), 64'hA5A5_A5A5);
      chk("ovr_lo", 64'(lo), 64'hA5A5_A5A5);
      chk("ovr_nodrop", 64'(mt_drop), 64'd0);

      // reset mid-multiply aborts
      op_valid = 1'b1;
      op_a = 32'd9;
      op_b = 32'd9;
      tick();
      op_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("arst_hi", 64'(hi), 64'd0);
      chk("arst_lo", 64'(lo), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("arst_nodone", 64'(done), 64'd0);
      end
      chk("arst_ready", 64'(op_ready), 64'd1);
      chk("arst_lo_kept", 64'(lo), 64'd0);
      do_mul(32'd2, 32'd3, 32'd0, 32'd6, "post_rst");

      // streaming with op_valid held high
      op_valid = 1'b1;
      op_a = $urandom;
      op_b = $urandom;
      pa = '0;
      pb = '0;
      ntx = 0;
      for (int cyc = 0; cyc < 1000 && ntx < 100; cyc++) begin
         acc = op_ready;
         if (acc) begin
            pa = op_a;
            pb = op_b;
         end
         tick();
         if (acc) begin
            op_a = $urandom;
            op_b = $urandom;
         end
         if (busy) begin
            chk("stream_mula", 64'(mul_a), 64'(pa));
            chk("stream_mulb", 64'(mul_b), 64'(pb));
         end
         if (done) begin
            exp_p = 64'($signed(longint'($signed(pa)) * longint'($signed(pb))));
            chk("stream_hilo", {hi, lo}, exp_p);
            ntx++;
         end
      end
      op_valid = 1'b0;
      chk("stream_count", 64'(ntx), 64'd100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
